// File: rtl/div_defs.sv
// Shared definitions for the sequential signed divider: widths, FSM
// encodings and the result payload carried from fixup to the outputs.
package div_defs;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  localparam logic [DIV_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } div_state_e;

  typedef struct packed {
    logic [DIV_W-1:0] quot;
    logic [DIV_W-1:0] rem;
    logic             exc;
  } div_result_t;

endpackage

// File: rtl/add32.sv
// 32-bit adder with carry in and carry out.
module add32
  import div_defs::*;
(
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  input  logic             cin,
  output logic [DIV_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (DIV_W+1)'(cin);

endmodule

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module div_step
  import div_defs::*;
(
  input  logic [DIV_W:0]   rem,
  input  logic             dbit,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W:0]   rem_next,
  output logic             qbit
);

  logic [DIV_W:0]   shifted;
  logic [DIV_W-1:0] diff;
  logic             carry;

  assign shifted = {rem[DIV_W-1:0], dbit};

  // shifted - divisor as shifted + ~divisor + 1; carry out means no borrow
  add32 u_sub (
    .a    (shifted[DIV_W-1:0]),
    .b    (~divisor),
    .cin  (1'b1),
    .sum  (diff),
    .cout (carry)
  );

  // Anything with a bit at or above 2^32 already exceeds the divisor.
  assign qbit     = rem[DIV_W] | shifted[DIV_W] | carry;
  assign rem_next = qbit ? {1'b0, diff} : shifted;

endmodule

// File: rtl/negate32.sv
// 32-bit two's-complement negation.
module negate32
  import div_defs::*;
(
  input  logic [DIV_W-1:0] a,
  output logic [DIV_W-1:0] y
);

  assign y = ~a + DIV_W'(1);

endmodule

// File: rtl/div32_seq.sv
// Sequential signed 32-bit divider: operand magnitudes, 32 restoring
// iterations, sign fixup, then a one-cycle data_resultRDY pulse.
module div32_seq
  import div_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [DIV_W-1:0] data_operandA,
  input  logic [DIV_W-1:0] data_operandB,
  output logic [DIV_W-1:0] data_result,
  output logic [DIV_W-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DIV_W:0]   rem_q, rem_nxt;
  logic [DIV_W-1:0] quo_q, quo_nxt;
  logic [DIV_W-1:0] dvs_q, dvs_nxt;
  logic             sign_a, sign_a_nxt;
  logic             sign_b, sign_b_nxt;
  logic             ovf_q, ovf_nxt;
  div_result_t      pend_q, pend_nxt;

  logic [DIV_W-1:0] result_nxt, remainder_nxt;
  logic             exception_nxt, rdy_nxt;

  logic [DIV_W-1:0] neg_a, neg_r_in, neg_r, neg_q;
  logic [DIV_W:0]   step_rem;
  logic             step_qbit;

  negate32 u_neg_opa (
    .a (data_operandA),
    .y (neg_a)
  );

  // Shared: negates B on a start edge, the remainder during fixup.
  // A start in FIXUP aborts the fixup, so the two uses never collide.
  assign neg_r_in = ctrl_div ? data_operandB : rem_q[DIV_W-1:0];

  negate32 u_neg_rem (
    .a (neg_r_in),
    .y (neg_r)
  );

  negate32 u_neg_quo (
    .a (quo_q),
    .y (neg_q)
  );

  // Dividend bits leave quo_q from the MSB while quotient bits enter at the LSB.
  div_step u_step (
    .rem      (rem_q),
    .dbit     (quo_q[DIV_W-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  // Next-state and datapath update; a start pulse overrides any state.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rem_nxt       = rem_q;
    quo_nxt       = quo_q;
    dvs_nxt       = dvs_q;
    sign_a_nxt    = sign_a;
    sign_b_nxt    = sign_b;
    ovf_nxt       = ovf_q;
    pend_nxt      = pend_q;
    result_nxt    = data_result;
    remainder_nxt = data_remainder;
    exception_nxt = data_exception;
    rdy_nxt       = 1'b0;

    if (ctrl_div) begin
      sign_a_nxt = data_operandA[DIV_W-1];
      sign_b_nxt = data_operandB[DIV_W-1];
      quo_nxt    = data_operandA[DIV_W-1] ? neg_a : data_operandA;
      dvs_nxt    = data_operandB[DIV_W-1] ? neg_r : data_operandB;
      rem_nxt    = '0;
      cnt_nxt    = '0;
      ovf_nxt    = (data_operandA == INT_MIN) && (data_operandB == '1);
      if (data_operandB == '0) begin
        pend_nxt.quot = '0;
        pend_nxt.rem  = '0;
        pend_nxt.exc  = 1'b1;
        state_nxt     = S_DONE;
      end else begin
        state_nxt = S_DIVIDE;
      end
    end else begin
      case (state)
        S_DIVIDE: begin
          rem_nxt = step_rem;
          quo_nxt = {quo_q[DIV_W-2:0], step_qbit};
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_ITERS - 1)) begin
            state_nxt = S_FIXUP;
          end
        end
        S_FIXUP: begin
          pend_nxt.quot = ovf_q ? INT_MIN : ((sign_a ^ sign_b) ? neg_q : quo_q);
          pend_nxt.rem  = ovf_q ? '0 : (sign_a ? neg_r : rem_q[DIV_W-1:0]);
          pend_nxt.exc  = ovf_q;
          state_nxt     = S_DONE;
        end
        S_DONE: begin
          result_nxt    = pend_q.quot;
          remainder_nxt = pend_q.rem;
          exception_nxt = pend_q.exc;
          rdy_nxt       = 1'b1;
          state_nxt     = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset wins over a same-edge start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      ovf_q          <= 1'b0;
      pend_q         <= '0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      rem_q          <= rem_nxt;
      quo_q          <= quo_nxt;
      dvs_q          <= dvs_nxt;
      sign_a         <= sign_a_nxt;
      sign_b         <= sign_b_nxt;
      ovf_q          <= ovf_nxt;
      pend_q         <= pend_nxt;
      data_result    <= result_nxt;
      data_remainder <= remainder_nxt;
      data_exception <= exception_nxt;
      data_resultRDY <= rdy_nxt;
    end
  end

endmodule

// File: doc/div32_seq.md
# div32_seq

Sequential signed 32-bit integer divider for the processor's execute stage, producing quotient and remainder by restoring division over 32 iterations. It consumes the existing 2's-complement negation block to form operand magnitudes and to apply result signs. The pipeline stalls on `data_resultRDY`.

## Interface
- Parameters: none. Width is fixed at 32 bits.
- `clock` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `ctrl_div` input, 1 bit: start pulse; operands are sampled on the edge where it is high.
- `data_operandA` input, 32 bits: dividend, signed 2's complement.
- `data_operandB` input, 32 bits: divisor, signed 2's complement.
- `data_result` output, 32 bits: quotient, signed.
- `data_remainder` output, 32 bits: remainder, signed.
- `data_exception` output, 1 bit: divide-by-zero or overflow flag; valid while `data_resultRDY` is high.
- `data_resultRDY` output, 1 bit: one-cycle pulse marking valid result, remainder and exception.

## Operation
- States: IDLE, DIVIDE, FIXUP, DONE.
- **Reset.** State goes to IDLE. `data_result`, `data_remainder`, `data_exception` and `data_resultRDY` all go to 0. The iteration counter goes to 0.
- **Start.** `ctrl_div=1` on an edge latches:
  - sign bits of A and B;
  - |A| and |B| as 32-bit unsigned values, using negation when the sign bit is set (|0x80000000| = 2^31 is correct as unsigned);
  - the 33-bit partial remainder, cleared to 0.
- **Divide-by-zero.** If B==0 at start, next state is DONE with result 0, remainder 0, exception 1.
- **Normal start.** Otherwise the next state is DIVIDE with the counter at 0.
- **DIVIDE.** One restoring step per cycle, MSB first:
  - shift the remainder left and bring in the next dividend bit;
  - trial-subtract |B|;
  - if the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - After 32 steps, next state is FIXUP.
- **FIXUP.**
  - Quotient is negated if signA XOR signB.
  - Remainder is negated if signA (the remainder takes the dividend's sign).
  - Overflow case A=0x80000000, B=0xFFFFFFFF: result 0x80000000, remainder 0, exception 1.
  - Next state is DONE.
- **DONE.** `data_resultRDY=1` for exactly this one cycle, then IDLE. Outputs hold their values until the next start or reset.
- **Start in a non-IDLE state.** `ctrl_div=1` in DIVIDE, FIXUP or DONE aborts the current operation and restarts with the new operands. No `data_resultRDY` pulse is produced for the aborted operation.
- **Reset priority.** Reset takes priority over `ctrl_div` on the same edge.

## Timing
- Define T as the edge where `ctrl_div=1` is sampled.
- **Normal divide.** Iterations occur on edges T+1 through T+32. FIXUP completes on edge T+33. `data_resultRDY` is high in the cycle following edge T+34 and low again after edge T+35. Total latency is 34 edges.
- **Divide-by-zero.** `data_resultRDY` is high in the cycle following edge T+1.
- **No pipelining.** There is one operation in flight at a time. Operands need only be valid at edge T.
- **Exception.** `data_exception` updates at the same edge as the result. It is 0 for every normal completion.

## Structure
- Shared package/header `div_defs` holds:
  - state encodings `S_IDLE=2'd0`, `S_DIVIDE=2'd1`, `S_FIXUP=2'd2`, `S_DONE=2'd3`;
  - `DIV_ITERS=32`;
  - `INT_MIN=32'h80000000`.
- Existing blocks are reused: three negation instances (operand magnitude, quotient fixup, remainder fixup) and the 32-bit adder for the trial subtract.
- One new sub-module is natural: `div_step`, a combinational single restoring iteration.
  - Inputs: 33-bit remainder, dividend bit, 32-bit divisor.
  - Outputs: next remainder, quotient bit.

## Test plan
- **Positive operands.** 100 / 7 at T → at T+34: result=14, remainder=2, exception=0, `data_resultRDY` high exactly one cycle.
- **Mixed signs.** -100 / 7 → result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Also 100 / -7 → -14, 2. Also -100 / -7 → 14, -2.
- **Overflow.** 0x80000000 / 0xFFFFFFFF → result=0x80000000, remainder 0, exception=1. Also 0x80000000 / 1 → 0x80000000, exception 0.
- **Divide-by-zero.** 12345 / 0 → `data_resultRDY` after edge T+1, result 0, remainder 0, exception 1.
- **Restart mid-operation.** Start 100/7, then `ctrl_div` at T+10 with 9/3 → a single `data_resultRDY`, 34 edges after the second start, result=3, remainder=0.
- **Reset mid-operation.** Assert `reset` at T+15 → all outputs 0, no `data_resultRDY` ever follows for that operation.
